// File: rtl/load_store_unit_if.sv
// -----------------------------------------------------------------------------
// load_store_unit_if
// Word-wide data memory bus between the load/store unit and the memory port.
//
// Signals:
//   mem_req    master->slave  access request, held until mem_ready
//   mem_we     master->slave  1 = write, 0 = read
//   mem_addr   master->slave  word-aligned byte address (bits [1:0] = 0)
//   mem_be     master->slave  per-byte lane enables
//   mem_wdata  master->slave  lane-positioned write data
//   mem_ready  slave->master  access accepted/completed this cycle
//   mem_rdata  slave->master  read data, valid with mem_ready on a read
//
// Modports: master (load/store unit side), slave (memory side).
// -----------------------------------------------------------------------------
interface load_store_unit_if #(
  parameter int XLEN = 32
) ();
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [3:0]      mem_be;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_ready;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Multi-cycle memory access stage. Accepts one LOAD/STORE at a time, turns the
// byte/half/word access into word-aligned bus transactions with byte enables,
// and returns the raw right-aligned load data (extension is done upstream).
//
// Ports:
//   clk, reset_n          clock; synchronous active-low reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_is_store          1 = store, 0 = load
//   req_funct3            RISC-V load/store funct3
//   req_addr              effective byte address
//   req_store_val         store data (rs2)
//   resp_valid            one-cycle completion pulse
//   resp_error            with resp_valid: illegal funct3, misaligned, timeout
//   load_val              right-aligned load bytes, held until the next load
//   mem                   data memory bus (load_store_unit_if.master)
//
// Optional feature: define LSU_MISALIGNED_SPLIT_EN to execute accesses that
// cross a word boundary as two word accesses (ACC0 then ACC1). When it is not
// defined, such accesses complete immediately with resp_error=1.
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_is_store,
  input  logic [2:0]          req_funct3,
  input  logic [XLEN-1:0]     req_addr,
  input  logic [XLEN-1:0]     req_store_val,
  output logic                resp_valid,
  output logic                resp_error,
  output logic [XLEN-1:0]     load_val,
  load_store_unit_if.master   mem
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  state_t          state_reg, state_next;
  logic            is_store_reg;
  logic [1:0]      size_reg;       // funct3[1:0]: 00 byte, 01 half, 10 word
  logic [XLEN-1:0] addr_reg;
  logic [XLEN-1:0] store_val_reg;
  logic [XLEN-1:0] load_val_reg;
  logic            err_reg;
  logic [CW-1:0]   cnt_reg;

  // ---------------- request decode ----------------
  logic [2:0] req_size;
  logic       req_legal;
  logic       req_misaligned;
  logic       req_reject;

  always_comb begin
    case (req_funct3[1:0])
      2'b00:   req_size = 3'd1;
      2'b01:   req_size = 3'd2;
      default: req_size = 3'd4;
    endcase
    if (req_is_store)
      req_legal = (req_funct3[2] == 1'b0) && (req_funct3[1:0] != 2'b11);
    else
      req_legal = (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    // offset + size > 4 means the access crosses into the next word
    req_misaligned = ({1'b0, req_addr[1:0]} + req_size) > 3'd4;
`ifdef LSU_MISALIGNED_SPLIT_EN
    req_reject = !req_legal;
`else
    req_reject = !req_legal || req_misaligned;
`endif
  end

  // ---------------- lane steering of the latched request ----------------
  logic [1:0]      off;
  logic [3:0]      size_be;
  logic [XLEN-1:0] byte_mask;
  logic [4:0]      sh0;
  logic [XLEN-1:0] rdata0;
  logic [XLEN-1:0] word_addr;

  assign off       = addr_reg[1:0];
  assign sh0       = {off, 3'b000};
  assign word_addr = {addr_reg[XLEN-1:2], 2'b00};

  always_comb begin
    case (size_reg)
      2'b00:   size_be = 4'b0001;
      2'b01:   size_be = 4'b0011;
      default: size_be = 4'b1111;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane_mask
      assign byte_mask[8*gi +: 8] = {8{size_be[gi]}};
    end
  endgenerate

  assign rdata0 = (mem.mem_rdata >> sh0) & byte_mask;

`ifdef LSU_MISALIGNED_SPLIT_EN
  logic            split_reg;
  logic [XLEN-1:0] acc_reg;       // low part gathered by ACC0
  logic [1:0]      off_inv;       // (4 - off) mod 4; off is never 0 in ACC1
  logic [4:0]      sh1;
  logic [XLEN-1:0] rdata1;

  assign off_inv = 2'd0 - off;
  assign sh1     = {off_inv, 3'b000};
  assign rdata1  = (acc_reg | (mem.mem_rdata << sh1)) & byte_mask;
`endif

  // Fires on the last waiting cycle so the error response follows it directly.
  logic timeout_hit;
  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timeout
      assign timeout_hit = !mem.mem_ready && (cnt_reg == CW'(TIMEOUT_CYCLES - 1));
    end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end
  endgenerate

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next    = state_reg;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    resp_error    = 1'b0;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_be    = 4'b0000;
    mem.mem_wdata = '0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = req_reject ? RESP : ACC0;
      end
      ACC0: begin
        mem.mem_req   = 1'b1;
        mem.mem_we    = is_store_reg;
        mem.mem_addr  = word_addr;
        mem.mem_be    = size_be << off;
        mem.mem_wdata = store_val_reg << sh0;
        if (mem.mem_ready) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
          state_next = split_reg ? ACC1 : RESP;
`else
          state_next = RESP;
`endif
        end else if (timeout_hit) begin
          state_next = RESP;
        end
      end
`ifdef LSU_MISALIGNED_SPLIT_EN
      ACC1: begin
        mem.mem_req   = 1'b1;
        mem.mem_we    = is_store_reg;
        mem.mem_addr  = word_addr + XLEN'(4);
        mem.mem_be    = size_be >> off_inv;
        mem.mem_wdata = store_val_reg >> sh1;
        if (mem.mem_ready || timeout_hit) state_next = RESP;
      end
`endif
      RESP: begin
        resp_valid = 1'b1;
        resp_error = err_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      is_store_reg  <= 1'b0;
      size_reg      <= 2'b00;
      addr_reg      <= '0;
      store_val_reg <= '0;
      load_val_reg  <= '0;
      err_reg       <= 1'b0;
      cnt_reg       <= '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
      split_reg     <= 1'b0;
      acc_reg       <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: if (req_valid) begin
          is_store_reg  <= req_is_store;
          size_reg      <= req_funct3[1:0];
          addr_reg      <= req_addr;
          store_val_reg <= req_store_val;
          err_reg       <= req_reject;
          cnt_reg       <= '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
          split_reg     <= req_misaligned;
`endif
        end
        ACC0: if (mem.mem_ready) begin
          cnt_reg <= '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
          if (split_reg)          acc_reg      <= rdata0;
          else if (!is_store_reg) load_val_reg <= rdata0;
`else
          if (!is_store_reg) load_val_reg <= rdata0;
`endif
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
          if (timeout_hit) err_reg <= 1'b1;
        end
`ifdef LSU_MISALIGNED_SPLIT_EN
        ACC1: if (mem.mem_ready) begin
          if (!is_store_reg) load_val_reg <= rdata1;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
          if (timeout_hit) err_reg <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign load_val = load_val_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Directed, table-driven bench for load_store_unit. Each table record holds a
// request, the bus transactions it must produce (up to two), the read data the
// memory returns, and the expected error flag and load_val. Hand-written
// sequences cover wait states, the access timeout and reset during an access.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_store_val;
  logic        resp_valid;
  logic        resp_error;
  logic [31:0] load_val;

  load_store_unit_if #(.XLEN(32)) mem_bus ();

  load_store_unit #(.XLEN(32), .TIMEOUT_CYCLES(16)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_is_store  (req_is_store),
    .req_funct3    (req_funct3),
    .req_addr      (req_addr),
    .req_store_val (req_store_val),
    .resp_valid    (resp_valid),
    .resp_error    (resp_error),
    .load_val      (load_val),
    .mem           (mem_bus.master)
  );

  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  typedef struct {
    logic        is_store;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sval;
    int          n_acc;
    logic [31:0] a0;
    logic [3:0]  be0;
    logic [31:0] wd0;
    logic [31:0] rd0;
    logic [31:0] a1;
    logic [3:0]  be1;
    logic [31:0] wd1;
    logic [31:0] rd1;
    logic        err;
    logic [31:0] lv;
  } vec_t;

  function automatic vec_t mk(
    input logic is_store, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] sval,
    input int n_acc,
    input logic [31:0] a0, input logic [3:0] be0, input logic [31:0] wd0, input logic [31:0] rd0,
    input logic [31:0] a1, input logic [3:0] be1, input logic [31:0] wd1, input logic [31:0] rd1,
    input logic err, input logic [31:0] lv);
    vec_t v;
    v.is_store = is_store; v.f3 = f3; v.addr = addr; v.sval = sval; v.n_acc = n_acc;
    v.a0 = a0; v.be0 = be0; v.wd0 = wd0; v.rd0 = rd0;
    v.a1 = a1; v.be1 = be1; v.wd1 = wd1; v.rd1 = rd1;
    v.err = err; v.lv = lv;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] sval);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = addr; req_store_val = sval;
    @(negedge clk);
    req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b000; req_addr = '0; req_store_val = '0;
  endtask

  // Memory answers every request immediately; response is expected in
  // cycle n_acc+1 (cycle 1 when no access is made).
  task automatic run_vec(input vec_t v, input string tag);
    int cyc, nacc, resp_cyc, exp_cyc;
    chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
    drive_req(v.is_store, v.f3, v.addr, v.sval);
    cyc = 1; nacc = 0; resp_cyc = -1;
    while (resp_cyc < 0 && cyc <= 20) begin
      mem_bus.mem_ready = 1'b0;
      if (mem_bus.mem_req) begin
        if (nacc < 2) begin
          chk($sformatf("%s addr%0d", tag, nacc), mem_bus.mem_addr, (nacc == 0) ? v.a0 : v.a1);
          chk($sformatf("%s be%0d", tag, nacc), 32'(mem_bus.mem_be),
              32'((nacc == 0) ? v.be0 : v.be1));
          chk($sformatf("%s we%0d", tag, nacc), 32'(mem_bus.mem_we), 32'(v.is_store));
          if (v.is_store)
            chk($sformatf("%s wdata%0d", tag, nacc), mem_bus.mem_wdata, (nacc == 0) ? v.wd0 : v.wd1);
          mem_bus.mem_rdata = (nacc == 0) ? v.rd0 : v.rd1;
        end
        mem_bus.mem_ready = 1'b1;
        nacc++;
      end
      if (resp_valid) begin
        resp_cyc = cyc;
        chk({tag, " resp_error"}, 32'(resp_error), 32'(v.err));
        chk({tag, " load_val"}, load_val, v.lv);
      end
      @(negedge clk);
      cyc++;
    end
    mem_bus.mem_ready = 1'b0;
    exp_cyc = (v.n_acc == 0) ? 1 : v.n_acc + 1;
    chk({tag, " n_access"}, 32'(nacc), 32'(v.n_acc));
    chk({tag, " resp_cycle"}, 32'(resp_cyc), 32'(exp_cyc));
    $display("[TB] %s st=%0d f3=%b addr=0x%08h accesses=%0d resp_cycle=%0d err=%0b load_val=0x%08h",
             tag, v.is_store, v.f3, v.addr, nacc, resp_cyc, resp_error, load_val);
  endtask

  // LW with nwait cycles of mem_ready=0 before ready (large nwait = never).
  task automatic run_wait(input string tag, input logic [31:0] addr, input logic [31:0] rdata,
                          input int nwait, input int exp_cyc, input logic exp_err,
                          input logic [31:0] exp_lv);
    int cyc, resp_cyc, waits;
    chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
    drive_req(1'b0, 3'b010, addr, 32'h0);
    cyc = 1; resp_cyc = -1; waits = 0;
    while (resp_cyc < 0 && cyc <= 40) begin
      mem_bus.mem_ready = 1'b0;
      if (resp_valid) begin
        resp_cyc = cyc;
        chk({tag, " resp_error"}, 32'(resp_error), 32'(exp_err));
        chk({tag, " load_val"}, load_val, exp_lv);
        chk({tag, " mem_req in resp"}, 32'(mem_bus.mem_req), 32'd0);
      end else begin
        chk($sformatf("%s mem_req c%0d", tag, cyc), 32'(mem_bus.mem_req), 32'd1);
        chk($sformatf("%s addr c%0d", tag, cyc), mem_bus.mem_addr, {addr[31:2], 2'b00});
        if (waits >= nwait) begin
          mem_bus.mem_ready = 1'b1;
          mem_bus.mem_rdata = rdata;
        end else begin
          waits++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    mem_bus.mem_ready = 1'b0;
    chk({tag, " resp_cycle"}, 32'(resp_cyc), 32'(exp_cyc));
    $display("[TB] %s addr=0x%08h waits=%0d resp_cycle=%0d err=%0b load_val=0x%08h",
             tag, addr, waits, resp_cyc, resp_error, load_val);
  endtask

`ifdef LSU_MISALIGNED_SPLIT_EN
  localparam logic [31:0] LV_END = 32'h55443322;
`else
  localparam logic [31:0] LV_END = 32'h00000077;
`endif

  vec_t vecs[16];

  initial begin
    vecs[0]  = mk(0, 3'b010, 32'h100, 32'h0, 1, 32'h100, 4'b1111, 32'h0, 32'hDEADBEEF,
                  32'h0, 4'b0, 32'h0, 32'h0, 0, 32'hDEADBEEF);
    vecs[1]  = mk(0, 3'b000, 32'h103, 32'h0, 1, 32'h100, 4'b1000, 32'h0, 32'h8A000000,
                  32'h0, 4'b0, 32'h0, 32'h0, 0, 32'h0000008A);
    vecs[2]  = mk(1, 3'b001, 32'h102, 32'h1234, 1, 32'h100, 4'b1100, 32'h12340000, 32'h0,
                  32'h0, 4'b0, 32'h0, 32'h0, 0, 32'h0000008A);
    vecs[3]  = mk(0, 3'b100, 32'h101, 32'h0, 1, 32'h100, 4'b0010, 32'h0, 32'h11223344,
                  32'h0, 4'b0, 32'h0, 32'h0, 0, 32'h00000033);
    vecs[4]  = mk(0, 3'b101, 32'h202, 32'h0, 1, 32'h200, 4'b1100, 32'h0, 32'hA5B6C7D8,
                  32'h0, 4'b0, 32'h0, 32'h0, 0, 32'h0000A5B6);
    vecs[5]  = mk(0, 3'b001, 32'h300, 32'h0, 1, 32'h300, 4'b0011, 32'h0, 32'hFFFF8001,
                  32'h0, 4'b0, 32'h0, 32'h0, 0, 32'h00008001);
    vecs[6]  = mk(1, 3'b000, 32'h401, 32'hAABBCCDD, 1, 32'h400, 4'b0010, 32'hBBCCDD00, 32'h0,
                  32'h0, 4'b0, 32'h0, 32'h0, 0, 32'h00008001);
    vecs[7]  = mk(1, 3'b010, 32'h404, 32'hCAFEF00D, 1, 32'h404, 4'b1111, 32'hCAFEF00D, 32'h0,
                  32'h0, 4'b0, 32'h0, 32'h0, 0, 32'h00008001);
    vecs[8]  = mk(0, 3'b011, 32'h100, 32'h0, 0, 32'h0, 4'b0, 32'h0, 32'h0,
                  32'h0, 4'b0, 32'h0, 32'h0, 1, 32'h00008001);
    vecs[9]  = mk(1, 3'b100, 32'h100, 32'h55, 0, 32'h0, 4'b0, 32'h0, 32'h0,
                  32'h0, 4'b0, 32'h0, 32'h0, 1, 32'h00008001);
    vecs[10] = mk(0, 3'b000, 32'h002, 32'h0, 1, 32'h000, 4'b0100, 32'h0, 32'hFF77FFFF,
                  32'h0, 4'b0, 32'h0, 32'h0, 0, 32'h00000077);
`ifdef LSU_MISALIGNED_SPLIT_EN
    vecs[11] = mk(1, 3'b010, 32'h206, 32'hDDCCBBAA, 2, 32'h204, 4'b1100, 32'hBBAA0000, 32'h0,
                  32'h208, 4'b0011, 32'h0000DDCC, 32'h0, 0, 32'h00000077);
    vecs[12] = mk(0, 3'b001, 32'h203, 32'h0, 2, 32'h200, 4'b1000, 32'h0, 32'hAB000000,
                  32'h204, 4'b0001, 32'h0, 32'h000000CD, 0, 32'h0000CDAB);
    vecs[13] = mk(0, 3'b010, 32'h101, 32'h0, 2, 32'h100, 4'b1110, 32'h0, 32'h44332211,
                  32'h104, 4'b0001, 32'h0, 32'h88776655, 0, 32'h55443322);
`else
    vecs[11] = mk(1, 3'b010, 32'h206, 32'hDDCCBBAA, 0, 32'h0, 4'b0, 32'h0, 32'h0,
                  32'h0, 4'b0, 32'h0, 32'h0, 1, 32'h00000077);
    vecs[12] = mk(0, 3'b001, 32'h203, 32'h0, 0, 32'h0, 4'b0, 32'h0, 32'h0,
                  32'h0, 4'b0, 32'h0, 32'h0, 1, 32'h00000077);
    vecs[13] = mk(0, 3'b010, 32'h101, 32'h0, 0, 32'h0, 4'b0, 32'h0, 32'h0,
                  32'h0, 4'b0, 32'h0, 32'h0, 1, 32'h00000077);
`endif
    vecs[14] = mk(1, 3'b111, 32'h100, 32'h0, 0, 32'h0, 4'b0, 32'h0, 32'h0,
                  32'h0, 4'b0, 32'h0, 32'h0, 1, LV_END);
    vecs[15] = mk(0, 3'b110, 32'h100, 32'h0, 0, 32'h0, 4'b0, 32'h0, 32'h0,
                  32'h0, 4'b0, 32'h0, 32'h0, 1, LV_END);

    reset_n = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_store_val = '0;
    mem_bus.mem_ready = 1'b0; mem_bus.mem_rdata = '0;
    repeat (3) @(negedge clk);

    chk("reset req_ready",  32'(req_ready), 32'd1);
    chk("reset resp_valid", 32'(resp_valid), 32'd0);
    chk("reset resp_error", 32'(resp_error), 32'd0);
    chk("reset load_val",   load_val, 32'h0);
    chk("reset mem_req",    32'(mem_bus.mem_req), 32'd0);
    chk("reset mem_we",     32'(mem_bus.mem_we), 32'd0);
    chk("reset mem_addr",   mem_bus.mem_addr, 32'h0);
    chk("reset mem_be",     32'(mem_bus.mem_be), 32'd0);
    chk("reset mem_wdata",  mem_bus.mem_wdata, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Wait states: ready in cycle 4 -> response in cycle 5.
    run_wait("wait3", 32'h600, 32'h0BADF00D, 3, 5, 1'b0, 32'h0BADF00D);
    // Timeout: 16 waiting cycles (1..16), error response in cycle 17.
    run_wait("timeout", 32'h500, 32'h12345678, 1000, 17, 1'b1, 32'h0BADF00D);

    // Reset while in ACC0 aborts the access without a response.
    chk("rst req_ready", 32'(req_ready), 32'd1);
    drive_req(1'b0, 3'b010, 32'h700, 32'h0);
    chk("rst mem_req c1", 32'(mem_bus.mem_req), 32'd1);
    @(negedge clk);
    chk("rst mem_req c2", 32'(mem_bus.mem_req), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("rst mem_req after",    32'(mem_bus.mem_req), 32'd0);
    chk("rst req_ready after",  32'(req_ready), 32'd1);
    chk("rst resp_valid after", 32'(resp_valid), 32'd0);
    chk("rst load_val after",   load_val, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rst quiet resp_valid %0d", i), 32'(resp_valid), 32'd0);
      chk($sformatf("rst quiet mem_req %0d", i), 32'(mem_bus.mem_req), 32'd0);
    end
    $display("[TB] reset during ACC0: access dropped, unit idle");
    run_vec(vecs[0], "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, %0d tests run, %0d failed", n_run, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Multi-cycle memory access stage between instruction_compute and the data memory port.
- Consumes store data plus the effective address/funct3 of LOAD/STORE instructions.
- Returns the raw, right-aligned load_val that instruction_compute sign- or zero-extends.
- Converts byte/half/word accesses into word-aligned memory transactions with byte enables and a valid/ready handshake.

Parameters:
XLEN, 32, data/address width; only 32 is supported.
TIMEOUT_CYCLES, 16, max cycles to wait for mem_ready per access; 0 disables the timeout.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset_n  in  1  synchronous, active-low reset.
req_valid  in  1  request present; sampled only while req_ready=1.
req_ready  out  1  unit idle and able to accept a request.
req_is_store  in  1  1=store, 0=load.
req_funct3  in  3  RISC-V load/store funct3.
req_addr  in  XLEN  effective byte address.
req_store_val  in  XLEN  rs2 value for stores.
resp_valid  out  1  one-cycle pulse: access complete.
resp_error  out  1  valid with resp_valid: illegal funct3, misaligned access, or timeout.
load_val  out  XLEN  right-aligned loaded bytes, upper bits zero; held until the next accepted load.
mem_req  out  1  memory request; held until mem_ready.
mem_we  out  1  write enable.
mem_addr  out  XLEN  word-aligned address; bits [1:0] always 0.
mem_be  out  4  byte enables.
mem_wdata  out  XLEN  lane-shifted write data.
mem_ready  in  1  memory accepts/completes the current access this cycle.
mem_rdata  in  XLEN  read data, valid in the cycle mem_ready=1 with mem_we=0.

Behaviour:
- Reset (reset_n=0 at an edge): state=IDLE, req_ready=1, resp_valid=0, resp_error=0, load_val=0, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, timeout counter=0.
- Reset asserted mid-access aborts the access; mem_req is 0 from the next cycle. No response is issued.
- States: IDLE, ACC0, ACC1, RESP.
- IDLE: req_ready=1. On req_valid, latch all req_* fields.
  - Legal funct3: loads 000/001/010/100/101; stores 000/001/010.
  - Size n=1/2/4; offset o=addr[1:0].
  - Illegal funct3 -> RESP with error and no memory access.
  - Otherwise -> ACC0.
- Misalignment: o+n>4 is misaligned. Without the optional feature it goes IDLE->RESP with error and no memory access.
- ACC0:
  - mem_req=1, mem_addr={addr[31:2],2'b00}, mem_we=is_store.
  - mem_be=(mask(n)<<o)[3:0], mem_wdata=store_val<<8*o.
  - Outputs stay stable until mem_ready.
  - On mem_ready: capture rdata>>8*o, masked to n bytes. Then -> ACC1 if split, else -> RESP.
- ACC1 (split only):
  - mem_addr=word+4, mem_be=mask(n)>>(4-o), mem_wdata=store_val>>8*(4-o).
  - On mem_ready: OR in rdata<<8*(4-o), mask to n bytes, -> RESP.
- RESP: resp_valid=1 for exactly one cycle, mem_req=0, load_val updated (loads only), -> IDLE. req_ready=0 in ACC0/ACC1/RESP.
- Latency:
  - Request accepted in cycle 0.
  - mem_req asserted in cycle 1.
  - mem_ready in cycle k gives resp_valid in cycle k+1.
  - Minimum request-to-response: 2 cycles.
  - Error without access: resp_valid in cycle 1.
- Timeout: the counter resets on entering each ACC state and increments while mem_req=1 and mem_ready=0. When it reaches TIMEOUT_CYCLES, the access is dropped -> RESP with error and load_val unchanged.
- mem_ready while mem_req=0 is ignored.

Optional Feature:
- Macro: LSU_MISALIGNED_SPLIT_EN.
- Defined: an access with o+n>4 executes as two word accesses (ACC0 then ACC1), with results merged as above, and no error.
- Undefined: ACC1 is not synthesized, and misaligned requests return resp_error=1 without touching memory.

Test Plan:
1. LW at addr 0x100, mem_rdata=0xDEADBEEF, mem_ready on first mem_req cycle -> mem_addr=0x100, mem_be=1111; resp_valid 2 cycles after accept; load_val=0xDEADBEEF; resp_error=0.
2. LB at 0x103 with rdata 0x8A000000, then SH at 0x102 with store_val 0x1234 -> load_val=0x0000008A; store gives mem_be=1100, mem_wdata=0x12340000, mem_we=1.
3. SW at 0x206 -> with LSU_MISALIGNED_SPLIT_EN: two writes, (0x204, be 1100, wdata 0xBBAA0000) then (0x208, be 0011, wdata 0x0000DDCC) for store_val 0xDDCCBBAA. Without the macro: no mem_req, resp_error=1.
4. mem_ready held low, TIMEOUT_CYCLES=16 -> resp_valid with resp_error=1 after the 16th waiting cycle; load_val keeps its previous value.
5. reset_n pulled low while in ACC0 -> mem_req=0 and req_ready=1 the next cycle; no resp_valid; a subsequent LW completes normally.
6. funct3=011 load and funct3=100 store -> resp_error=1 in cycle 1; mem_req never asserted.
